// File: rtl/bridge_ctrl_if.sv
// Request/bus/response signal bundle for bridge_ctrl.
//   req_*   : parsed host requests (single-cycle valid pulse, no backpressure)
//   bus_*_o : request issued onto the register bus (one-cycle strobe)
//   bus_*_i : read return from the end of the core chain
//   resp_*  : read result to the bridge transmitter (valid/ready)
//   timeout_o, overflow_o, busy_o : status
// Modport slave is the bridge_ctrl side, master is the driving side.
interface bridge_ctrl_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
) ();
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic [DATA_WIDTH-1:0] req_data_i;
   logic                  req_rw_i;
   logic                  req_valid_i;
   logic [ADDR_WIDTH-1:0] bus_addr_o;
   logic [DATA_WIDTH-1:0] bus_data_o;
   logic                  bus_rw_o;
   logic                  bus_valid_o;
   logic [DATA_WIDTH-1:0] bus_data_i;
   logic                  bus_valid_i;
   logic [DATA_WIDTH-1:0] resp_data_o;
   logic                  resp_valid_o;
   logic                  resp_ready_i;
   logic                  timeout_o;
   logic                  overflow_o;
   logic                  busy_o;

   modport slave (
      input  req_addr_i, req_data_i, req_rw_i, req_valid_i,
             bus_data_i, bus_valid_i, resp_ready_i,
      output bus_addr_o, bus_data_o, bus_rw_o, bus_valid_o,
             resp_data_o, resp_valid_o, timeout_o, overflow_o, busy_o
   );

   modport master (
      output req_addr_i, req_data_i, req_rw_i, req_valid_i,
             bus_data_i, bus_valid_i, resp_ready_i,
      input  bus_addr_o, bus_data_o, bus_rw_o, bus_valid_o,
             resp_data_o, resp_valid_o, timeout_o, overflow_o, busy_o
   );
endinterface

// File: rtl/bridge_ctrl.sv
// Request sequencer between the ASCII host-bridge parser and the register bus.
// Parsed requests are queued in a small FIFO, issued one at a time as a
// one-cycle bus strobe, and reads wait (with timeout) for return data which
// is then offered to the transmitter with a valid/ready handshake.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bif   : bridge_ctrl_if.slave (request, bus, response and status signals)
module bridge_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   bridge_ctrl_if.slave bif
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TLAST_C = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_RESP} state_t;

   state_t                state;
   logic [TW-1:0]         timer;

   logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
   logic                  mem_rw   [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  fifo_push;
   logic                  fifo_pop;

   logic [ADDR_WIDTH-1:0] bus_addr_q;
   logic [DATA_WIDTH-1:0] bus_data_q;
   logic                  bus_rw_q;
   logic                  bus_valid_q;
   logic [DATA_WIDTH-1:0] resp_data_q;
   logic                  resp_valid_q;
   logic                  timeout_q;
   logic                  overflow_q;

   // The head is only consumed from IDLE, so at most one transaction is
   // ever in flight. A pop frees a slot, letting a push land even when full.
   assign fifo_pop  = (state == S_IDLE) && (count != '0);
   assign fifo_push = bif.req_valid_i && ((count != DEPTH_C) || fifo_pop);

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (fifo_push) begin
         mem_addr[wr_ptr] <= bif.req_addr_i;
         mem_data[wr_ptr] <= bif.req_data_i;
         mem_rw[wr_ptr]   <= bif.req_rw_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
         if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (fifo_push && !fifo_pop)      count <= count + 1'b1;
         else if (!fifo_push && fifo_pop) count <= count - 1'b1;
         if (bif.req_valid_i && !fifo_push) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         timer        <= '0;
         bus_addr_q   <= '0;
         bus_data_q   <= '0;
         bus_rw_q     <= 1'b0;
         bus_valid_q  <= 1'b0;
         resp_data_q  <= '0;
         resp_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         bus_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (fifo_pop) begin
                  bus_addr_q  <= mem_addr[rd_ptr];
                  bus_data_q  <= mem_rw[rd_ptr] ? mem_data[rd_ptr] : '0;
                  bus_rw_q    <= mem_rw[rd_ptr];
                  bus_valid_q <= 1'b1;
                  state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (bus_rw_q) begin
                  state <= S_IDLE;
               end else begin
                  timer <= '0;
                  state <= S_WAIT_RD;
               end
            end
            S_WAIT_RD: begin
               timer <= timer + 1'b1;
               // Return data wins over expiry in the same cycle.
               if (bif.bus_valid_i) begin
                  resp_data_q  <= bif.bus_data_i;
                  resp_valid_q <= 1'b1;
                  state        <= S_RESP;
               end else if (timer == TLAST_C) begin
                  resp_data_q  <= '0;
                  resp_valid_q <= 1'b1;
                  timeout_q    <= 1'b1;
                  state        <= S_RESP;
               end
            end
            S_RESP: begin
               if (bif.resp_ready_i) begin
                  resp_valid_q <= 1'b0;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bif.bus_addr_o   = bus_addr_q;
   assign bif.bus_data_o   = bus_data_q;
   assign bif.bus_rw_o     = bus_rw_q;
   assign bif.bus_valid_o  = bus_valid_q;
   assign bif.resp_data_o  = resp_data_q;
   assign bif.resp_valid_o = resp_valid_q;
   assign bif.timeout_o    = timeout_q;
   assign bif.overflow_o   = overflow_q;
   assign bif.busy_o       = (state != S_IDLE) || (count != '0);
endmodule

// File: tb/tb_bridge_ctrl.sv
// Self-checking bench for bridge_ctrl: directed scenarios followed by random
// traffic, all outputs compared every cycle against a transaction-level model.
module tb_bridge_ctrl;
   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int TMO   = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bridge_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

   bridge_ctrl #(
      .FIFO_DEPTH (DEPTH),
      .TIMEOUT    (TMO),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bif   (bif)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          rw;
   } req_t;

   req_t          q[$];
   req_t          m_head;
   bit            m_active = 0, m_strobe = 0, m_wait = 0, m_rpend = 0;
   bit            m_tmo = 0, m_ovf = 0, m_was_active = 0, m_was_strobe = 0;
   int            m_waited = 0;
   logic [AW-1:0] m_baddr = '0;
   logic [DW-1:0] m_bdata = '0;
   logic [DW-1:0] m_rdata = '0;
   logic          m_brw = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_active = 0; m_strobe = 0; m_wait = 0; m_rpend = 0;
         m_tmo = 0; m_ovf = 0; m_waited = 0;
         m_baddr = '0; m_bdata = '0; m_rdata = '0; m_brw = 1'b0;
      end else begin
         m_was_active = m_active;
         m_was_strobe = m_strobe;
         m_strobe = 0;
         m_tmo    = 0;
         if (m_rpend) begin
            if (bif.resp_ready_i) begin
               m_rpend  = 0;
               m_active = 0;
            end
         end else if (m_wait) begin
            m_waited++;
            if (bif.bus_valid_i) begin
               m_rdata = bif.bus_data_i; m_wait = 0; m_rpend = 1;
            end else if (m_waited == TMO) begin
               m_rdata = '0; m_tmo = 1; m_wait = 0; m_rpend = 1;
            end
         end else if (m_was_strobe) begin
            if (m_brw) m_active = 0;
            else begin
               m_wait = 1; m_waited = 0;
            end
         end
         if (!m_was_active && q.size() != 0) begin
            m_head   = q.pop_front();
            m_baddr  = m_head.a;
            m_bdata  = m_head.rw ? m_head.d : '0;
            m_brw    = m_head.rw;
            m_strobe = 1;
            m_active = 1;
         end
         if (bif.req_valid_i) begin
            if (q.size() < DEPTH) q.push_back('{bif.req_addr_i, bif.req_data_i, bif.req_rw_i});
            else m_ovf = 1;
         end
      end
   end

   // ---------------- read responder ----------------
   int            rd_delay = 3;   // cycles after a read strobe; <= 0 means never
   int            rd_cnt   = 0;
   bit            rd_rand  = 0;
   bit            spur_en  = 0;
   logic [DW-1:0] rd_val   = 16'hCAFE;

   initial begin
      bif.bus_valid_i = 1'b0;
      bif.bus_data_i  = '0;
      forever begin
         @(negedge clk);
         bif.bus_valid_i = 1'b0;
         if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               bif.bus_valid_i = 1'b1;
               bif.bus_data_i  = rd_rand ? 16'($urandom) : rd_val;
            end
         end else if (spur_en && $urandom_range(0, 19) == 0) begin
            bif.bus_valid_i = 1'b1;
            bif.bus_data_i  = 16'($urandom);
         end
         if (bif.bus_valid_o && !bif.bus_rw_o && rd_delay > 0) rd_cnt = rd_delay;
      end
   end

   // ---------------- per-cycle stepping ----------------
   logic [31:0] ev_log[$];   // strobe addresses; 32'h1_0000 marks a response handshake

   task automatic tick();
      @(negedge clk);
      check("bus_valid",  32'(bif.bus_valid_o),  32'(m_strobe));
      check("bus_addr",   32'(bif.bus_addr_o),   32'(m_baddr));
      check("bus_data",   32'(bif.bus_data_o),   32'(m_bdata));
      check("bus_rw",     32'(bif.bus_rw_o),     32'(m_brw));
      check("resp_valid", 32'(bif.resp_valid_o), 32'(m_rpend));
      check("resp_data",  32'(bif.resp_data_o),  32'(m_rdata));
      check("timeout",    32'(bif.timeout_o),    32'(m_tmo));
      check("overflow",   32'(bif.overflow_o),   32'(m_ovf));
      check("busy",       32'(bif.busy_o),       32'(m_active || q.size() != 0));
      if (bif.bus_valid_o) ev_log.push_back(32'(bif.bus_addr_o));
      if (bif.resp_valid_o && bif.resp_ready_i) ev_log.push_back(32'h1_0000);
      bif.req_valid_i = 1'b0;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rw);
      bif.req_addr_i  = a;
      bif.req_data_i  = d;
      bif.req_rw_i    = rw;
      bif.req_valid_i = 1'b1;
      tick();
   endtask

   // which: 0 = bus_valid_o, 1 = timeout_o, 2 = resp_valid_o
   task automatic wait_sig(input string tag, input int which, output int n);
      logic s;
      n = -1;
      for (int i = 1; i <= 64; i++) begin
         tick();
         case (which)
            0:       s = bif.bus_valid_o;
            1:       s = bif.timeout_o;
            default: s = bif.resp_valid_o;
         endcase
         if (s) begin
            n = i;
            return;
         end
      end
      check({tag, "_wait_expired"}, 32'(0), 32'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int  n;
      bit  seen;
      bif.req_addr_i   = '0;
      bif.req_data_i   = '0;
      bif.req_rw_i     = 1'b0;
      bif.req_valid_i  = 1'b0;
      bif.resp_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rst_busy", 32'(bif.busy_o), 32'(0));
      check("rst_ovf",  32'(bif.overflow_o), 32'(0));

      // 1: single write, strobe two cycles after the request
      push(16'h1234, 16'h5678, 1'b1);
      check("t1_early", 32'(bif.bus_valid_o), 32'(0));
      tick();
      check("t1_strobe", 32'(bif.bus_valid_o), 32'(1));
      check("t1_addr",   32'(bif.bus_addr_o),  32'h1234);
      check("t1_data",   32'(bif.bus_data_o),  32'h5678);
      check("t1_rw",     32'(bif.bus_rw_o),    32'(1));
      seen = 0;
      repeat (4) begin tick(); if (bif.resp_valid_o) seen = 1; end
      check("t1_no_resp", 32'(seen), 32'(0));

      // 2: read answered three cycles after the strobe
      rd_val = 16'hCAFE; rd_delay = 3;
      push(16'hBABE, 16'hFFFF, 1'b0);
      wait_sig("t2_strobe", 0, n);
      check("t2_addr", 32'(bif.bus_addr_o), 32'hBABE);
      check("t2_data", 32'(bif.bus_data_o), 32'h0000);
      check("t2_rw",   32'(bif.bus_rw_o),   32'(0));
      wait_sig("t2_resp", 2, n);
      check("t2_resp_lat",  32'(n), 32'(4));
      check("t2_resp_data", 32'(bif.resp_data_o), 32'hCAFE);
      tick();
      check("t2_resp_drop", 32'(bif.resp_valid_o), 32'(0));

      // 3: read with no return data times out after TMO cycles of waiting
      rd_delay = 0;
      push(16'h0001, 16'h0000, 1'b0);
      wait_sig("t3_strobe", 0, n);
      wait_sig("t3_tmo", 1, n);
      check("t3_tmo_lat",   32'(n), 32'(TMO + 1));
      check("t3_resp",      32'(bif.resp_valid_o), 32'(1));
      check("t3_resp_data", 32'(bif.resp_data_o), 32'h0000);
      tick();
      check("t3_pulse", 32'(bif.timeout_o), 32'(0));
      check("t3_idle",  32'(bif.busy_o),    32'(0));

      // 3b: data on the last waiting cycle is a response, not a timeout
      rd_val = 16'h7E57; rd_delay = TMO;
      push(16'h0002, 16'h0000, 1'b0);
      wait_sig("t3b_strobe", 0, n);
      wait_sig("t3b_resp", 2, n);
      check("t3b_lat",    32'(n), 32'(TMO + 1));
      check("t3b_no_tmo", 32'(bif.timeout_o), 32'(0));
      check("t3b_data",   32'(bif.resp_data_o), 32'h7E57);
      repeat (3) tick();

      // 4: FIFO fills behind a stalled read; fifth write is dropped
      rd_val = 16'h4444; rd_delay = 6; bif.resp_ready_i = 1'b0;
      push(16'h0003, 16'h0000, 1'b0);
      wait_sig("t4_strobe", 0, n);
      for (int i = 0; i < 5; i++) push(16'hA000 + 16'(i), 16'h0100 + 16'(i), 1'b1);
      check("t4_ovf", 32'(bif.overflow_o), 32'(1));
      wait_sig("t4_resp", 2, n);
      check("t4_resp_data", 32'(bif.resp_data_o), 32'h4444);
      repeat (2) tick();
      check("t4_resp_hold", 32'(bif.resp_data_o), 32'h4444);
      bif.resp_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_sig("t4_wr", 0, n);
         check("t4_wr_addr", 32'(bif.bus_addr_o), 32'hA000 + 32'(i));
         check("t4_wr_gap",  32'(n), 32'(2));
      end
      seen = 0;
      repeat (6) begin tick(); if (bif.bus_valid_o) seen = 1; end
      check("t4_no_fifth", 32'(seen), 32'(0));
      check("t4_ovf_sticky", 32'(bif.overflow_o), 32'(1));

      // 5: W, R, W on consecutive cycles; second write waits for the handshake
      rd_val = 16'h1111; rd_delay = 3;
      ev_log.delete();
      push(16'hDEAD, 16'hBEEF, 1'b1);
      push(16'hF00D, 16'h0000, 1'b0);
      push(16'hB0BA, 16'hCAFE, 1'b1);
      repeat (20) tick();
      check("t5_events", 32'(ev_log.size()), 32'(4));
      if (ev_log.size() == 4) begin
         check("t5_ev0", ev_log[0], 32'hDEAD);
         check("t5_ev1", ev_log[1], 32'hF00D);
         check("t5_ev2", ev_log[2], 32'h1_0000);
         check("t5_ev3", ev_log[3], 32'hB0BA);
      end

      // 6: reset while waiting on a read with two requests queued
      rd_delay = 5;
      push(16'h0600, 16'h0000, 1'b0);
      wait_sig("t6_strobe", 0, n);
      push(16'h0601, 16'h1111, 1'b1);
      push(16'h0602, 16'h2222, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_bus_valid", 32'(bif.bus_valid_o),  32'(0));
      check("t6_bus_addr",  32'(bif.bus_addr_o),   32'(0));
      check("t6_bus_data",  32'(bif.bus_data_o),   32'(0));
      check("t6_bus_rw",    32'(bif.bus_rw_o),     32'(0));
      check("t6_resp",      32'(bif.resp_valid_o), 32'(0));
      check("t6_resp_data", 32'(bif.resp_data_o),  32'(0));
      check("t6_tmo",       32'(bif.timeout_o),    32'(0));
      check("t6_ovf",       32'(bif.overflow_o),   32'(0));
      check("t6_busy",      32'(bif.busy_o),       32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin tick(); if (bif.bus_valid_o || bif.resp_valid_o) seen = 1; end
      check("t6_quiet", 32'(seen), 32'(0));
      check("t6_idle",  32'(bif.busy_o), 32'(0));

      // random traffic, including late and spurious return strobes
      rd_rand = 1; spur_en = 1;
      for (int c = 0; c < 800; c++) begin
         bif.resp_ready_i = ($urandom_range(0, 3) != 0);
         rd_delay = $urandom_range(1, TMO + 2);
         if ($urandom_range(0, 2) == 0) begin
            bif.req_addr_i  = 16'($urandom);
            bif.req_data_i  = 16'($urandom);
            bif.req_rw_i    = 1'($urandom_range(0, 1));
            bif.req_valid_i = 1'b1;
         end
         tick();
      end
      spur_en = 0;
      bif.resp_ready_i = 1'b1;
      repeat (80) tick();
      check("end_idle", 32'(bif.busy_o), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
